// File: rtl/cu_wf_completion_model.sv
// ---------------------------------------------------------------------------
// cu_wf_completion_model
//
// Purpose:
//   Cycle-level stand-in for a set of compute units, used for dispatcher
//   simulation and FPGA bring-up. Each CU owns SLOTS_PER_CU wavefront slots.
//   A dispatch lands in the lowest free slot of the addressed CU with a
//   countdown latency. When a countdown reaches zero the wavefront is retired
//   and its tag is reported back to the dispatcher. Each CU retires at most
//   one wavefront per cycle.
//
//   In the default build the latency is LAT_MIN plus a masked slice of a
//   16-bit Galois LFSR (taps 0xB400). The LFSR is seeded with LFSR_SEED and
//   advances every cycle out of reset.
//
// Optional feature macro:
//   CU_SIM_FIXED_LAT_EN - when defined, the LFSR is removed and every dispatch
//   runs for exactly LAT_MIN cycles. LAT_MASK and LFSR_SEED are then unused.
//
// Ports:
//   clk                          clock
//   rst                          asynchronous, active-low reset
//   dispatch2cu_wf_dispatch      per-CU dispatch strobe (one-hot or zero)
//   dispatch2cu_wf_tag_dispatch  tag of the dispatched wavefront
//   all_wf_dispatched            dispatcher has issued its final wavefront
//   cu2dispatch_wf_done          per-CU completion pulse (registered)
//   cu2dispatch_wf_tag_done      completed tag, CU i at [i*TAG_WIDTH +: TAG_WIDTH]
//   cu_full                      all slots of CU i valid (combinational)
//   overflow_err                 sticky: dispatch addressed a full CU
//   protocol_err                 sticky: more than one dispatch bit in a cycle
//   idle                         registered: all dispatched, nothing in flight
//
// The load sum LAT_MIN + LAT_MASK must fit in LAT_WIDTH bits, and
// LAT_WIDTH must not exceed the 16-bit LFSR width.
// ---------------------------------------------------------------------------
module cu_wf_completion_model #(
  parameter int                   NUMBER_CU    = 8,
  parameter int                   CU_ID_WIDTH  = 3,
  parameter int                   TAG_WIDTH    = 15,
  parameter int                   SLOTS_PER_CU = 8,
  parameter int                   LAT_WIDTH    = 9,
  parameter int                   LAT_MIN      = 4,
  parameter logic [LAT_WIDTH-1:0] LAT_MASK     = 9'h0FF,
  parameter logic [15:0]          LFSR_SEED    = 16'hACE1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUMBER_CU-1:0]           dispatch2cu_wf_dispatch,
  input  logic [TAG_WIDTH-1:0]           dispatch2cu_wf_tag_dispatch,
  input  logic                           all_wf_dispatched,
  output logic [NUMBER_CU-1:0]           cu2dispatch_wf_done,
  output logic [NUMBER_CU*TAG_WIDTH-1:0] cu2dispatch_wf_tag_done,
  output logic [NUMBER_CU-1:0]           cu_full,
  output logic                           overflow_err,
  output logic                           protocol_err,
  output logic                           idle
);

  localparam int SLOT_IDX_W = (SLOTS_PER_CU > 1) ? $clog2(SLOTS_PER_CU) : 1;

  // Per-slot state: valid bit, wavefront tag and remaining latency.
  logic [SLOTS_PER_CU-1:0] slotValid_q [NUMBER_CU];
  logic [SLOTS_PER_CU-1:0] slotValid_d [NUMBER_CU];
  logic [TAG_WIDTH-1:0]    slotTag_q   [NUMBER_CU][SLOTS_PER_CU];
  logic [TAG_WIDTH-1:0]    slotTag_d   [NUMBER_CU][SLOTS_PER_CU];
  logic [LAT_WIDTH-1:0]    slotCnt_q   [NUMBER_CU][SLOTS_PER_CU];
  logic [LAT_WIDTH-1:0]    slotCnt_d   [NUMBER_CU][SLOTS_PER_CU];

  // Registered completion interface and status flags.
  logic [NUMBER_CU-1:0]           done_q, done_d;
  logic [NUMBER_CU*TAG_WIDTH-1:0] tagDone_q, tagDone_d;
  logic                           overflowErr_q, overflowErr_d;
  logic                           protocolErr_q, protocolErr_d;
  logic                           idle_q, idle_d;

  // Per-CU slot scan results.
  logic [NUMBER_CU-1:0]  freeFound;
  logic [NUMBER_CU-1:0]  doneFound;
  logic [SLOT_IDX_W-1:0] freeIdx [NUMBER_CU];
  logic [SLOT_IDX_W-1:0] doneIdx [NUMBER_CU];

  // Dispatch decode.
  logic                   dispAny;
  logic                   dispMulti;
  logic                   dispOne;
  logic [CU_ID_WIDTH-1:0] dispCuIdx;

  logic                 anyValid;
  logic [LAT_WIDTH-1:0] loadCnt;

`ifdef CU_SIM_FIXED_LAT_EN
  // Fixed-latency build: every wavefront runs for LAT_MIN cycles.
  assign loadCnt = LAT_WIDTH'(LAT_MIN);
`else
  // Galois LFSR supplying the random part of the latency. It free-runs from
  // reset release, so the latency sequence is reproducible run to run.
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Parameter constraint keeps this sum inside LAT_WIDTH, so no wrap.
  assign loadCnt = LAT_WIDTH'(LAT_MIN) + (lfsr_q[LAT_WIDTH-1:0] & LAT_MASK);
`endif

  // Scan each CU for its lowest free slot and its lowest expired slot. Both
  // use the pre-edge valid bits, so a slot retired at an edge cannot be
  // refilled by a dispatch sampled at that same edge.
  always_comb begin
    for (int c = 0; c < NUMBER_CU; c++) begin
      freeFound[c] = 1'b0;
      freeIdx[c]   = '0;
      doneFound[c] = 1'b0;
      doneIdx[c]   = '0;
      for (int s = SLOTS_PER_CU - 1; s >= 0; s--) begin
        if (!slotValid_q[c][s]) begin
          freeFound[c] = 1'b1;
          freeIdx[c]   = SLOT_IDX_W'(s);
        end
        if (slotValid_q[c][s] && (slotCnt_q[c][s] == '0)) begin
          doneFound[c] = 1'b1;
          doneIdx[c]   = SLOT_IDX_W'(s);
        end
      end
    end
  end

  // Classify the dispatch vector. Clearing the lowest set bit leaves a
  // non-zero value only when two or more bits are set.
  always_comb begin
    dispAny   = |dispatch2cu_wf_dispatch;
    dispMulti = |(dispatch2cu_wf_dispatch &
                  (dispatch2cu_wf_dispatch - NUMBER_CU'(1)));
    dispOne   = dispAny && !dispMulti;
    dispCuIdx = '0;
    for (int i = 0; i < NUMBER_CU; i++) begin
      if (dispatch2cu_wf_dispatch[i]) begin
        dispCuIdx = CU_ID_WIDTH'(i);
      end
    end
  end

  // A CU is full when every slot holds a running wavefront.
  always_comb begin
    anyValid = 1'b0;
    for (int c = 0; c < NUMBER_CU; c++) begin
      cu_full[c] = &slotValid_q[c];
      anyValid   = anyValid | (|slotValid_q[c]);
    end
  end

  // Next-state for slots and completion outputs. Counting, retirement and
  // allocation touch disjoint slots: a loading slot was invalid, a retiring
  // slot already sits at zero, so their order here does not matter.
  always_comb begin
    slotValid_d = slotValid_q;
    slotTag_d   = slotTag_q;
    slotCnt_d   = slotCnt_q;
    done_d      = '0;
    tagDone_d   = tagDone_q;

    for (int c = 0; c < NUMBER_CU; c++) begin
      for (int s = 0; s < SLOTS_PER_CU; s++) begin
        if (slotValid_q[c][s] && (slotCnt_q[c][s] != '0)) begin
          slotCnt_d[c][s] = slotCnt_q[c][s] - LAT_WIDTH'(1);
        end
      end

      if (doneFound[c]) begin
        slotValid_d[c][doneIdx[c]]           = 1'b0;
        done_d[c]                            = 1'b1;
        tagDone_d[c*TAG_WIDTH +: TAG_WIDTH]  = slotTag_q[c][doneIdx[c]];
      end

      if (dispOne && (dispCuIdx == CU_ID_WIDTH'(c)) && freeFound[c]) begin
        slotValid_d[c][freeIdx[c]] = 1'b1;
        slotTag_d[c][freeIdx[c]]   = dispatch2cu_wf_tag_dispatch;
        slotCnt_d[c][freeIdx[c]]   = loadCnt;
      end
    end
  end

  // Sticky error flags and registered idle. Idle needs the dispatcher to be
  // finished, no running slot, no completion pulse still on the outputs and
  // no dispatch presented this cycle.
  always_comb begin
    overflowErr_d = overflowErr_q |
                    (dispOne && (|(dispatch2cu_wf_dispatch & cu_full)));
    protocolErr_d = protocolErr_q | dispMulti;
    idle_d        = all_wf_dispatched && !anyValid && !(|done_q) && !dispAny;
  end

  // State registers. Reset discards every in-flight wavefront.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUMBER_CU; c++) begin
        slotValid_q[c] <= '0;
        for (int s = 0; s < SLOTS_PER_CU; s++) begin
          slotTag_q[c][s] <= '0;
          slotCnt_q[c][s] <= '0;
        end
      end
      done_q        <= '0;
      tagDone_q     <= '0;
      overflowErr_q <= 1'b0;
      protocolErr_q <= 1'b0;
      idle_q        <= 1'b0;
    end else begin
      slotValid_q   <= slotValid_d;
      slotTag_q     <= slotTag_d;
      slotCnt_q     <= slotCnt_d;
      done_q        <= done_d;
      tagDone_q     <= tagDone_d;
      overflowErr_q <= overflowErr_d;
      protocolErr_q <= protocolErr_d;
      idle_q        <= idle_d;
    end
  end

  assign cu2dispatch_wf_done     = done_q;
  assign cu2dispatch_wf_tag_done = tagDone_q;
  assign overflow_err            = overflowErr_q;
  assign protocol_err            = protocolErr_q;
  assign idle                    = idle_q;

endmodule

// File: tb/tb_cu_wf_completion_model.sv
// ---------------------------------------------------------------------------
// tb_cu_wf_completion_model
//
// Three instances of cu_wf_completion_model share one clock and reset:
//   A - LAT_MIN=12, LAT_MASK=0 : fixed latency 12. Used for the fill,
//                                overflow and protocol table, and for
//                                the reset test.
//   Z - LAT_MIN=0,  LAT_MASK=0 : zero latency, back-to-back completions.
//   R - default parameters     : random latency. A bench-side LFSR model
//                                predicts the earliest completion cycle.
// Expected completions are pushed to a scoreboard queue when a dispatch is
// driven. They are popped and compared when the DUT pulses done.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cu_wf_completion_model;

  localparam int          NCU        = 8;
  localparam int          TW         = 15;
  localparam int          SLOTS      = 8;
  localparam int          LW         = 9;
  localparam int          LAT_A      = 12;
  localparam int          LAT_Z      = 0;
  localparam int          LAT_R_MIN  = 4;
  localparam int          LAT_R_MASK = 255;
  localparam logic [15:0] SEED       = 16'hACE1;

  logic clk;
  logic rst;

  logic [NCU-1:0]    dispA, dispZ, dispR;
  logic [TW-1:0]     tagA, tagZ, tagR;
  logic              allA, allZ, allR;
  logic [NCU-1:0]    doneA, doneZ, doneR;
  logic [NCU*TW-1:0] tagDoneA, tagDoneZ, tagDoneR;
  logic [NCU-1:0]    fullA, fullZ, fullR;
  logic              ovfA, ovfZ, ovfR;
  logic              protoA, protoZ, protoR;
  logic              idleA, idleZ, idleR;

  cu_wf_completion_model #(.LAT_MIN(LAT_A), .LAT_MASK(9'h000)) dutA (
    .clk(clk), .rst(rst),
    .dispatch2cu_wf_dispatch(dispA), .dispatch2cu_wf_tag_dispatch(tagA),
    .all_wf_dispatched(allA),
    .cu2dispatch_wf_done(doneA), .cu2dispatch_wf_tag_done(tagDoneA),
    .cu_full(fullA), .overflow_err(ovfA), .protocol_err(protoA), .idle(idleA)
  );

  cu_wf_completion_model #(.LAT_MIN(LAT_Z), .LAT_MASK(9'h000)) dutZ (
    .clk(clk), .rst(rst),
    .dispatch2cu_wf_dispatch(dispZ), .dispatch2cu_wf_tag_dispatch(tagZ),
    .all_wf_dispatched(allZ),
    .cu2dispatch_wf_done(doneZ), .cu2dispatch_wf_tag_done(tagDoneZ),
    .cu_full(fullZ), .overflow_err(ovfZ), .protocol_err(protoZ), .idle(idleZ)
  );

  cu_wf_completion_model dutR (
    .clk(clk), .rst(rst),
    .dispatch2cu_wf_dispatch(dispR), .dispatch2cu_wf_tag_dispatch(tagR),
    .all_wf_dispatched(allR),
    .cu2dispatch_wf_done(doneR), .cu2dispatch_wf_tag_done(tagDoneR),
    .cu_full(fullR), .overflow_err(ovfR), .protocol_err(protoR), .idle(idleR)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    int           inst;
    int           cu;
    logic [TW-1:0] tag;
    int           issued;
    int           due;
  } sbEntry_t;

  typedef struct {
    logic [NCU-1:0] disp;
    logic [TW-1:0]  tag;
    bit             accept;
    int             cu;
    logic [NCU-1:0] expFull;
    bit             expOvf;
    bit             expProto;
  } vec_t;

  sbEntry_t    sb[$];
  vec_t        vecs[12];
  int          passCount = 0;
  int          checkCount = 0;
  int          cyc = 0;
  logic [15:0] lfsrModel = SEED;

  // Compare one value against its expected value and tally the result.
  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic int countCu(input int inst, input int cu);
    int n = 0;
    foreach (sb[k]) if (sb[k].inst == inst && sb[k].cu == cu) n++;
    return n;
  endfunction

  function automatic int countInst(input int inst);
    int n = 0;
    foreach (sb[k]) if (sb[k].inst == inst) n++;
    return n;
  endfunction

  function automatic logic [NCU-1:0] modelFullR();
    logic [NCU-1:0] f;
    for (int cu = 0; cu < NCU; cu++) f[cu] = (countCu(2, cu) >= SLOTS);
    return f;
  endfunction

  function automatic int findEntry(input int inst, input int cu,
                                   input logic [TW-1:0] tag, input bit matchTag);
    for (int k = 0; k < sb.size(); k++)
      if (sb[k].inst == inst && sb[k].cu == cu && (!matchTag || sb[k].tag == tag))
        return k;
    return -1;
  endfunction

  // Latency that instance R will load for a dispatch sampled at the next edge.
  function automatic int expLatR();
`ifdef CU_SIM_FIXED_LAT_EN
    return LAT_R_MIN;
`else
    return LAT_R_MIN + int'(lfsrModel[LW-1:0] & 9'(LAT_R_MASK));
`endif
  endfunction

  // Pop and check every completion pulse present after the current edge.
  task automatic monitorDone();
    logic [NCU-1:0]    dv;
    logic [NCU*TW-1:0] tv;
    logic [TW-1:0]     t;
    int                k;
    bit                ok;
    for (int inst = 0; inst < 3; inst++) begin
      case (inst)
        0:       begin dv = doneA; tv = tagDoneA; end
        1:       begin dv = doneZ; tv = tagDoneZ; end
        default: begin dv = doneR; tv = tagDoneR; end
      endcase
      for (int cu = 0; cu < NCU; cu++) begin
        if (dv[cu]) begin
          t = tv[cu*TW +: TW];
          k = findEntry(inst, cu, t, inst == 2);
          if (k < 0) begin
            checkCount++;
            $display("[TB] FAIL unexpected_done inst%0d cu%0d: got done with tag 0x%0h at cycle %0d, required no completion",
                     inst, cu, t, cyc);
          end else begin
            if (inst == 2) begin
              ok = (cyc >= sb[k].due) && (cyc <= sb[k].due + 2*SLOTS) &&
                   (cyc - sb[k].issued >= LAT_R_MIN + 1);
              checkCount++;
              if (ok) passCount++;
              else $display("[TB] FAIL latency_R cu%0d tag 0x%0h: got done at cycle %0d, required between %0d and %0d",
                            cu, t, cyc, sb[k].due, sb[k].due + 2*SLOTS);
            end else begin
              checkOutput($sformatf("tag_order inst%0d cu%0d", inst, cu), t, sb[k].tag);
              checkOutput($sformatf("done_cycle inst%0d cu%0d tag 0x%0h", inst, cu, t), cyc, sb[k].due);
            end
            sb.delete(k);
          end
        end
      end
    end
  endtask

  // Advance one clock edge, sample outputs 1 ns later.
  task automatic stepCycle();
    @(posedge clk);
    #1;
    cyc++;
    if (rst) lfsrModel = (lfsrModel >> 1) ^ (lfsrModel[0] ? 16'hB400 : 16'h0000);
    monitorDone();
  endtask

  // Drive one dispatch towards an instance and record the expected completion.
  task automatic applyStimulus(input int inst, input logic [NCU-1:0] disp,
                               input logic [TW-1:0] tag, input bit accept, input int cu);
    int       lat;
    sbEntry_t e;
    case (inst)
      0:       begin dispA = disp; tagA = tag; lat = LAT_A; end
      1:       begin dispZ = disp; tagZ = tag; lat = LAT_Z; end
      default: begin dispR = disp; tagR = tag; lat = expLatR(); end
    endcase
    if (accept) begin
      e.inst   = inst;
      e.cu     = cu;
      e.tag    = tag;
      e.issued = cyc + 1;
      e.due    = cyc + 1 + lat + 1;
      sb.push_back(e);
    end
  endtask

  task automatic clearInputs();
    dispA = '0; dispZ = '0; dispR = '0;
  endtask

  function automatic vec_t mkVec(input logic [NCU-1:0] disp, input logic [TW-1:0] tag,
                                 input bit accept, input int cu, input logic [NCU-1:0] expFull,
                                 input bit expOvf, input bit expProto);
    vec_t v;
    v.disp = disp; v.tag = tag; v.accept = accept; v.cu = cu;
    v.expFull = expFull; v.expOvf = expOvf; v.expProto = expProto;
    return v;
  endfunction

  initial begin
    int guard;
    int cu;

    // Fill CU0 of instance A, overflow it, send an illegal two-bit vector,
    // then a legal dispatch to CU2.
    for (int i = 0; i < 8; i++)
      vecs[i] = mkVec(8'h01, TW'(i + 1), 1'b1, 0, (i == 7) ? 8'h01 : 8'h00, 1'b0, 1'b0);
    vecs[8]  = mkVec(8'h01, 15'h0009, 1'b0, 0, 8'h01, 1'b1, 1'b0);
    vecs[9]  = mkVec(8'h05, 15'h0007, 1'b0, 0, 8'h01, 1'b1, 1'b1);
    vecs[10] = mkVec(8'h04, 15'h0123, 1'b1, 2, 8'h01, 1'b1, 1'b1);
    vecs[11] = mkVec(8'h00, 15'h0000, 1'b0, 0, 8'h01, 1'b1, 1'b1);

    rst = 1'b0;
    clearInputs();
    tagA = '0; tagZ = '0; tagR = '0;
    allA = 1'b0; allZ = 1'b0; allR = 1'b0;
    repeat (3) stepCycle();

    checkOutput("reset done", {doneA, doneZ, doneR}, '0);
    checkOutput("reset tag_done A", tagDoneA, '0);
    checkOutput("reset cu_full", {fullA, fullZ, fullR}, '0);
    checkOutput("reset errors", {ovfA, ovfZ, ovfR, protoA, protoZ, protoR}, '0);
    checkOutput("reset idle", {idleA, idleZ, idleR}, '0);
    rst = 1'b1;
    stepCycle();

    $display("[TB] table vectors on instance A");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, vecs[i].disp, vecs[i].tag, vecs[i].accept, vecs[i].cu);
      stepCycle();
      checkOutput($sformatf("vec%0d cu_full", i), fullA, vecs[i].expFull);
      checkOutput($sformatf("vec%0d overflow_err", i), ovfA, vecs[i].expOvf);
      checkOutput($sformatf("vec%0d protocol_err", i), protoA, vecs[i].expProto);
    end
    clearInputs();

    guard = 0;
    while (countInst(0) > 0 && guard < 60) begin stepCycle(); guard++; end
    checkOutput("drain A outstanding", countInst(0), 0);
    stepCycle();
    checkOutput("A done low after drain", doneA, '0);
    checkOutput("A tag hold cu0", tagDoneA[0*TW +: TW], 15'h0008);
    checkOutput("A tag hold cu2", tagDoneA[2*TW +: TW], 15'h0123);
    checkOutput("A cu_full after drain", fullA, '0);
    checkOutput("A errors sticky", {ovfA, protoA}, 2'b11);

    $display("[TB] zero latency back-to-back on instance Z");
    applyStimulus(1, 8'h02, 15'h0011, 1'b1, 1);
    stepCycle();
    applyStimulus(1, 8'h02, 15'h0022, 1'b1, 1);
    stepCycle();
    clearInputs();
    guard = 0;
    while (countInst(1) > 0 && guard < 10) begin stepCycle(); guard++; end
    checkOutput("drain Z outstanding", countInst(1), 0);

    $display("[TB] random latency, 200 wavefronts on instance R");
    for (int n = 0; n < 200; n++) begin
      cu = n % NCU;
      guard = 0;
      while (countCu(2, cu) >= SLOTS && guard < 600) begin
        clearInputs();
        stepCycle();
        checkOutput("R cu_full", fullR, modelFullR());
        guard++;
      end
      applyStimulus(2, NCU'(1) << cu, TW'(15'h1000 + n), 1'b1, cu);
      stepCycle();
      checkOutput("R cu_full", fullR, modelFullR());
    end
    clearInputs();
    allR = 1'b1;
    stepCycle();
    checkOutput("R idle while busy", idleR, 1'b0);
    guard = 0;
    while (countInst(2) > 0 && guard < 2000) begin stepCycle(); guard++; end
    checkOutput("drain R outstanding", countInst(2), 0);
    stepCycle();
    checkOutput("R idle one edge after last done", idleR, 1'b0);
    stepCycle();
    checkOutput("R idle rises", idleR, 1'b1);
    checkOutput("R errors", {ovfR, protoR}, 2'b00);

    $display("[TB] reset with wavefronts in flight on instance A");
    allR = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, NCU'(1) << i, TW'(15'h0500 + i), 1'b1, i);
      stepCycle();
    end
    clearInputs();
    stepCycle();
    stepCycle();
    rst = 1'b0;
    sb.delete();
    lfsrModel = SEED;
    repeat (3) stepCycle();
    rst = 1'b1;
    repeat (600) stepCycle();
    checkOutput("post-reset done", {doneA, doneZ, doneR}, '0);
    checkOutput("post-reset tag_done A", tagDoneA, '0);
    checkOutput("post-reset tag_done Z", tagDoneZ, '0);
    checkOutput("post-reset tag_done R", tagDoneR, '0);
    checkOutput("post-reset cu_full", {fullA, fullZ, fullR}, '0);
    checkOutput("post-reset errors", {ovfA, ovfZ, ovfR, protoA, protoZ, protoR}, '0);
    checkOutput("post-reset idle", {idleA, idleZ, idleR}, '0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
